ls_unit: RTL and testbench
==========================

Name: ls_unit

Overview:
Load/store unit feeding the register file write port (data_in/write_ctrl) and consuming its read outputs (selected register value, $dst = r15 as address). It runs a multi-cycle req/ack transaction to data memory. For loads it issues one register-file write; it asserts busy so the controller stalls the PC.

Parameters:
TIMEOUT, 16, max REQ-state cycles without mem_ack before abort; 0 = wait forever
CW, 5, width of wait counter; must hold TIMEOUT

Ports:
CLK  in  1  clock, all state on posedge
RST_N  in  1  reset, synchronous, active-low
start  in  1  decoder: begin load/store this cycle
is_store  in  1  1 = store, 0 = load; sampled with start
reg_sel  in  4  load destination register; sampled with start
rf_data  in  8  register-file data_out, the store value; sampled with start
rf_dst  in  8  register-file dst_out (r15), the memory address; sampled with start
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_addr  out  8  latched address
mem_wdata  out  8  latched store data
mem_ack  in  1  memory completes the transaction this cycle
mem_rdata  in  8  load data, valid with mem_ack
rf_write  out  1  register-file write_ctrl
rf_reg  out  4  register-file reg_in during writeback
rf_wdata  out  8  register-file data_in
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  one cycle, with done, on timeout abort

Behaviour:
- Reset (RST_N=0 at posedge): state IDLE, counter 0. All outputs 0, including any latched address/data. This holds even mid-transaction: mem_req drops the next cycle and no writeback occurs.
- States: IDLE, REQ, WB, [INC], DONE. All outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE: if start=1, latch is_store, reg_sel, rf_data and rf_dst, clear counter, go to REQ. start is ignored in every other state.
- REQ: mem_req=1, mem_we=latched is_store, mem_addr and mem_wdata stable.
  - mem_ack=1, store: go to DONE.
  - mem_ack=1, load: capture mem_rdata, go to WB.
  - Otherwise the counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack, go to DONE with err flagged and no writeback.
  - mem_ack is sampled only in REQ; ack in any other state is ignored.
- WB: rf_write=1 for exactly one cycle, with rf_reg=latched reg_sel and rf_wdata=captured data. Then go to INC if the feature is enabled, otherwise DONE.
- DONE: done=1, err=abort flag, for one cycle. Then go to IDLE. A start in DONE is ignored, since busy is still 1.
- Latency from start, with ack on the first REQ cycle: store done at +2; load write at +2, done at +3.
- A load whose destination is r15 overwrites the address register. The latched address is unaffected.
- rf_reg and rf_wdata are 0 whenever rf_write=0.

Optional Feature:
LSU_POSTINC_EN.
- Defined: the INC state is added and is visited after every successful load or store. In INC: rf_write=1, rf_reg=4'hF, rf_wdata=latched addr+1, mod 256, so 0xFF wraps to 0x00.
- For a load into r15, the INC write lands last and wins.
- Latency grows by 1 cycle.
- Aborted (timeout) transactions skip INC.
- Undefined: INC does not exist and r15 is never written by this block except as a load destination.

Decomposition:
- Package ls_pkg: state enum typedef (IDLE, REQ, WB, INC, DONE), RF_DST_IDX = 4'hF, default TIMEOUT constant.
- No sub-module needed; the wait counter stays inline.

Test Plan:
- Store: rf_dst=0x20, rf_data=0xA5, start. Memory acks on the 3rd REQ cycle. Required: mem_req high exactly 3 cycles with addr 0x20, wdata 0xA5, we=1; done 1 cycle after ack; rf_write never asserted.
- Load: reg_sel=3, rf_dst=0x40. Memory acks on the 1st REQ cycle with rdata 0x7E. Required: rf_write at +2 with rf_reg=3, rf_wdata=0x7E; done at +3; busy high from +1 through +3.
- Timeout with TIMEOUT=4 and no ack. Required: mem_req high 4 cycles, then done=1 and err=1; no rf_write; back in IDLE.
- Reset mid-REQ: assert RST_N=0 on the 2nd REQ cycle. Required: next cycle mem_req=0, busy=0, all outputs 0; a later ack is ignored.
- Start while busy: start pulses during REQ and DONE. Required: ignored, only one transaction observed. A back-to-back start the cycle after DONE is accepted.
- With LSU_POSTINC_EN, load into r15 at address 0xFF with rdata 0x11. Required: WB writes r15=0x11, then INC writes r15=0x00; done follows INC.

Source files
------------

// File: rtl/ls_pkg.sv
// Shared types and constants for the load/store unit.
package ls_pkg;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WB   = 3'd2,
    INC  = 3'd3,
    DONE = 3'd4
  } ls_state_t;

  // r15 holds the memory address and is the post-increment target.
  localparam logic [3:0] RF_DST_IDX = 4'hF;

  // Default ack wait limit in REQ cycles; 0 disables the abort.
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CW      = 5;

endpackage

// File: rtl/ls_unit.sv
// Load/store unit: a req/ack memory sequencer that writes load data back into
// the register file and holds busy so the controller stalls the PC.
//
// Optional build macro LSU_POSTINC_EN: after every successful load or store,
// an extra INC state writes r15 = latched address + 1 (mod 256).
//
// state | meaning
// IDLE  | waiting for start; all transaction outputs low
// REQ   | mem_req held, waiting for mem_ack or timeout
// WB    | single-cycle register-file write of load data
// INC   | single-cycle r15 post-increment write (LSU_POSTINC_EN only)
// DONE  | single-cycle done pulse (err set on timeout abort)
//
// Every output is a flop written at the same edge as the state it belongs to,
// so nothing combinational runs from an input to an output.
module ls_unit
  import ls_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = DEF_CW
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       is_store,
  input  logic [3:0] reg_sel,
  input  logic [7:0] rf_data,
  input  logic [7:0] rf_dst,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       rf_write,
  output logic [3:0] rf_reg,
  output logic [7:0] rf_wdata,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Last counter value allowed in REQ before aborting (unused when TIMEOUT=0).
  localparam int             TO_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0]  TO_M1  = CW'(TO_LIM);
  localparam bit             TO_EN  = (TIMEOUT != 0);

  ls_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_reg;
  logic [7:0]    r_addr;
  logic [7:0]    r_wdata;
  logic          r_mem_req;
  logic          r_mem_we;
  logic          r_rf_write;
  logic [3:0]    r_rf_reg;
  logic [7:0]    r_rf_wdata;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  // Sequencer: state, latched operands, wait counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_reg      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_rf_write <= 1'b0;
      r_rf_reg   <= '0;
      r_rf_wdata <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // Pulse-type outputs default low; rf_reg/rf_wdata are zero unless writing.
      r_rf_write <= 1'b0;
      r_rf_reg   <= '0;
      r_rf_wdata <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_reg     <= reg_sel;
            r_addr    <= rf_dst;
            r_wdata   <= rf_data;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
            r_mem_we  <= is_store;
            r_busy    <= 1'b1;
            r_state   <= REQ;
          end
        end

        REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_mem_we) begin
`ifdef LSU_POSTINC_EN
              r_rf_write <= 1'b1;
              r_rf_reg   <= RF_DST_IDX;
              r_rf_wdata <= r_addr + 8'd1;
              r_state    <= INC;
`else
              r_done     <= 1'b1;
              r_state    <= DONE;
`endif
            end else begin
              r_rf_write <= 1'b1;
              r_rf_reg   <= r_reg;
              r_rf_wdata <= mem_rdata;
              r_state    <= WB;
            end
          end else if (TO_EN && (r_cnt == TO_M1)) begin
            // Abort: no writeback and no post-increment.
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        WB: begin
`ifdef LSU_POSTINC_EN
          // Lands after the WB write, so a load into r15 ends at addr+1.
          r_rf_write <= 1'b1;
          r_rf_reg   <= RF_DST_IDX;
          r_rf_wdata <= r_addr + 8'd1;
          r_state    <= INC;
`else
          r_done     <= 1'b1;
          r_state    <= DONE;
`endif
        end

        INC: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end

        DONE: begin
          // busy is still high here, so a start this cycle is dropped.
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rf_write  = r_rf_write;
  assign rf_reg    = r_rf_reg;
  assign rf_wdata  = r_rf_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit (TIMEOUT=4). Build with +define+LSU_POSTINC_EN
// to exercise the post-increment variant; expectations follow the macro.
module tb_ls_unit;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start, is_store;
  logic [3:0] reg_sel;
  logic [7:0] rf_data, rf_dst;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       rf_write;
  logic [3:0] rf_reg;
  logic [7:0] rf_wdata;
  logic       busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle event tallies, sampled at the edge (values of the cycle just ended).
  int n_req = 0;
  int n_wr  = 0;
  int n_done = 0;
  int b_req, b_wr, b_done;

  ls_unit #(.TIMEOUT(4), .CW(5)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .start(start), .is_store(is_store), .reg_sel(reg_sel),
    .rf_data(rf_data), .rf_dst(rf_dst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_write(rf_write), .rf_reg(rf_reg), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    n_req  += int'(mem_req);
    n_wr   += int'(rf_write);
    n_done += int'(done);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    b_req  = n_req;
    b_wr   = n_wr;
    b_done = n_done;
  endtask

  task automatic go(input logic st, input logic [3:0] rs, input logic [7:0] d, input logic [7:0] a);
    start = 1'b1; is_store = st; reg_sel = rs; rf_data = d; rf_dst = a;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},  32'(mem_req),   32'h0);
    chk({tag, "_we"},   32'(mem_we),    32'h0);
    chk({tag, "_addr"}, 32'(mem_addr),  32'h0);
    chk({tag, "_wd"},   32'(mem_wdata), 32'h0);
    chk({tag, "_rfw"},  32'(rf_write),  32'h0);
    chk({tag, "_rfr"},  32'(rf_reg),    32'h0);
    chk({tag, "_rfd"},  32'(rf_wdata),  32'h0);
    chk({tag, "_busy"}, 32'(busy),      32'h0);
    chk({tag, "_done"}, 32'(done),      32'h0);
    chk({tag, "_err"},  32'(err),       32'h0);
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; is_store = 1'b0; reg_sel = '0;
    rf_data = '0; rf_dst = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk_zero("rst");
    RST_N = 1'b1;
    tick();

    // Store, ack on 3rd REQ cycle.
    snap();
    go(1'b1, 4'd9, 8'hA5, 8'h20);
    tick();
    start = 1'b0;
    chk("st_req1", 32'(mem_req), 32'h1);
    chk("st_we",   32'(mem_we), 32'h1);
    chk("st_addr", 32'(mem_addr), 32'h20);
    chk("st_wd",   32'(mem_wdata), 32'hA5);
    chk("st_busy", 32'(busy), 32'h1);
    tick();
    chk("st_req2", 32'(mem_req), 32'h1);
    tick();
    chk("st_req3", 32'(mem_req), 32'h1);
    chk("st_nodone", 32'(done), 32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("st_req_off", 32'(mem_req), 32'h0);
`ifdef LSU_POSTINC_EN
    chk("st_inc_w", 32'(rf_write), 32'h1);
    chk("st_inc_r", 32'(rf_reg), 32'hF);
    chk("st_inc_d", 32'(rf_wdata), 32'h21);
    tick();
`endif
    chk("st_done", 32'(done), 32'h1);
    chk("st_err",  32'(err), 32'h0);
    tick();
    chk("st_idle", 32'(busy), 32'h0);
    chk("st_ncyc_req", 32'(n_req - b_req), 32'd3);
`ifdef LSU_POSTINC_EN
    chk("st_nwr", 32'(n_wr - b_wr), 32'd1);
`else
    chk("st_nwr", 32'(n_wr - b_wr), 32'd0);
`endif
    chk("st_ndone", 32'(n_done - b_done), 32'd1);

    // Load, ack on 1st REQ cycle.
    snap();
    go(1'b0, 4'd3, 8'h00, 8'h40);
    tick();
    start = 1'b0;
    chk("ld_busy1", 32'(busy), 32'h1);
    chk("ld_we",    32'(mem_we), 32'h0);
    chk("ld_addr",  32'(mem_addr), 32'h40);
    mem_ack = 1'b1; mem_rdata = 8'h7E;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("ld_wr",   32'(rf_write), 32'h1);
    chk("ld_reg",  32'(rf_reg), 32'h3);
    chk("ld_dat",  32'(rf_wdata), 32'h7E);
    chk("ld_busy2", 32'(busy), 32'h1);
    chk("ld_nodone", 32'(done), 32'h0);
    tick();
`ifdef LSU_POSTINC_EN
    chk("ld_inc_r", 32'(rf_reg), 32'hF);
    chk("ld_inc_d", 32'(rf_wdata), 32'h41);
    tick();
`endif
    chk("ld_done",  32'(done), 32'h1);
    chk("ld_busy3", 32'(busy), 32'h1);
    chk("ld_wr0",   32'(rf_write), 32'h0);
    chk("ld_reg0",  32'(rf_reg), 32'h0);
    chk("ld_dat0",  32'(rf_wdata), 32'h0);
    tick();
    chk("ld_idle", 32'(busy), 32'h0);

    // Timeout: no ack, TIMEOUT=4.
    snap();
    go(1'b0, 4'd6, 8'h66, 8'h55);
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("to_done", 32'(done), 32'h1);
    chk("to_err",  32'(err), 32'h1);
    chk("to_req0", 32'(mem_req), 32'h0);
    tick();
    chk("to_idle", 32'(busy), 32'h0);
    chk("to_err0", 32'(err), 32'h0);
    chk("to_nreq", 32'(n_req - b_req), 32'd4);
    chk("to_nwr",  32'(n_wr - b_wr), 32'd0);

    // Reset on the 2nd REQ cycle, then a stray ack.
    snap();
    go(1'b0, 4'd5, 8'h5A, 8'h33);
    tick();
    start = 1'b0;
    tick();
    chk("rs_req", 32'(mem_req), 32'h1);
    RST_N = 1'b0;
    tick();
    chk_zero("rs_mid");
    RST_N = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h99;
    tick(); tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("rs_nwr",  32'(n_wr - b_wr), 32'd0);
    chk("rs_busy", 32'(busy), 32'h0);

    // Starts while busy are dropped; start right after DONE is accepted.
    snap();
    go(1'b1, 4'd0, 8'h01, 8'h10);
    tick();
    go(1'b1, 4'd0, 8'h02, 8'h77);
    tick();
    start = 1'b0;
    chk("sb_addr", 32'(mem_addr), 32'h10);
    chk("sb_wd",   32'(mem_wdata), 32'h01);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
`ifdef LSU_POSTINC_EN
    tick();
`endif
    chk("sb_done", 32'(done), 32'h1);
    go(1'b1, 4'd0, 8'h03, 8'h88);
    tick();
    chk("sb_drop", 32'(busy), 32'h0);
    chk("sb_ndone", 32'(n_done - b_done), 32'd1);
    go(1'b1, 4'd0, 8'h04, 8'h99);
    tick();
    start = 1'b0;
    chk("sb_b2b_busy", 32'(busy), 32'h1);
    chk("sb_b2b_addr", 32'(mem_addr), 32'h99);
    chk("sb_b2b_wd",   32'(mem_wdata), 32'h04);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
`ifdef LSU_POSTINC_EN
    tick();
`endif
    chk("sb_b2b_done", 32'(done), 32'h1);
    tick();
    chk("sb_ntrans", 32'(n_done - b_done), 32'd2);

    // Load into r15 at address 0xFF.
    go(1'b0, 4'hF, 8'h00, 8'hFF);
    tick();
    start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("r15_wb_reg", 32'(rf_reg), 32'hF);
    chk("r15_wb_dat", 32'(rf_wdata), 32'h11);
    tick();
`ifdef LSU_POSTINC_EN
    chk("r15_inc_w",   32'(rf_write), 32'h1);
    chk("r15_inc_reg", 32'(rf_reg), 32'hF);
    chk("r15_inc_dat", 32'(rf_wdata), 32'h00);
    chk("r15_inc_nd",  32'(done), 32'h0);
    tick();
`endif
    chk("r15_done", 32'(done), 32'h1);
    chk("r15_addr", 32'(mem_addr), 32'hFF);
    tick();
    chk("r15_idle", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
